dma_pcis_axi_wr_slave: RTL



---
 rtl/dma_pcis_axi_wr_slave.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dma_pcis_axi_wr_slave.sv
// AXI4 write-only slave on the PCIS DMA port: forwards each in-range W beat as one
// PCI-E packet on a valid/grant interface and returns one B response per burst.
module dma_pcis_axi_wr_slave #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 64,
    parameter int BEAT_SIZE  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [511:0]          wdata,
    input  logic [63:0]           wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [511:0]          packet_out,
    output logic                  packet_out_valid,
    input  logic                  packet_out_grant,
    output logic [31:0]           beats_forwarded
);

    typedef enum logic [1:0] {IDLE, DATA, DROP, RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [31:0]           fwd_q, fwd_d;
    logic                  bad_attr;
    logic                  err_beat;
    logic                  unused_addr_hi;

    // Only the low address bits matter: they decide 64-byte alignment.
    assign unused_addr_hi = ^awaddr[ADDR_WIDTH-1:6];
    assign bad_attr       = (awsize != 3'(BEAT_SIZE)) || (awaddr[5:0] != 6'd0);
    assign packet_out     = wdata;

    always_comb begin
        state_d          = state_q;
        id_d             = id_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        bvalid_d         = bvalid_q;
        bid_d            = bid_q;
        bresp_d          = bresp_q;
        fwd_d            = fwd_q;
        err_beat         = err_q;
        awready          = 1'b0;
        wready           = 1'b0;
        packet_out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    id_d    = awid;
                    len_d   = awlen;
                    cnt_d   = 8'd0;
                    err_d   = err_q | bad_attr;
                    state_d = DATA;
                end
            end
            DATA: begin
                wready           = packet_out_grant;
                packet_out_valid = wvalid;
                if (wvalid && packet_out_grant) begin
                    cnt_d    = cnt_q + 8'd1;
                    fwd_d    = (fwd_q != 32'hFFFF_FFFF) ? fwd_q + 32'd1 : fwd_q;
                    err_beat = err_q | (wstrb != '1);
                    if (wlast) begin
                        err_beat = err_beat | (cnt_q != len_q);
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = err_beat ? 2'b10 : 2'b00;
                        state_d  = RESP;
                    end else if (cnt_q == len_q) begin
                        // Master is sending more beats than it announced.
                        err_beat = 1'b1;
                        state_d  = DROP;
                    end
                    err_d = err_beat;
                end
            end
            DROP: begin
                wready = 1'b1;
                if (wvalid && wlast) begin
                    bvalid_d = 1'b1;
                    bid_d    = id_q;
                    bresp_d  = err_q ? 2'b10 : 2'b00;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= 2'b00;
            fwd_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            fwd_q    <= fwd_d;
        end
    end

    always_ff @(posedge clk) begin
        id_q  <= id_d;
        len_q <= len_d;
    end

    assign bvalid          = bvalid_q;
    assign bid             = bid_q;
    assign bresp           = bresp_q;
    assign beats_forwarded = fwd_q;

endmodule
